// File: rtl/vec_exec.sv
// rtl/vec_exec.sv - vector execute stage streaming one result element per cycle to write-back
// Latches a whole vector instruction, then emits op(a[i], b[i]) for i = 0..vl-1 over valid/ready.
module vec_exec #(
   parameter int DATA_W = 32,
   parameter int VLEN   = 8,
   parameter int IDX_W  = 3,
   parameter int REG_W  = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     issue_valid,
   output logic                     issue_ready,
   input  logic [2:0]               issue_op,
   input  logic [REG_W-1:0]         issue_vd,
   input  logic [IDX_W:0]           issue_vl,
   input  logic [DATA_W*VLEN-1:0]   issue_src_a,
   input  logic [DATA_W*VLEN-1:0]   issue_src_b,
   output logic                     wb_valid,
   input  logic                     wb_ready,
   output logic [REG_W-1:0]         wb_vd,
   output logic [IDX_W-1:0]         wb_idx,
   output logic [DATA_W-1:0]        wb_data,
   output logic                     wb_last,
   output logic                     busy
);

   localparam logic [0:0]     ST_IDLE = 1'b0;
   localparam logic [0:0]     ST_EXEC = 1'b1;
   localparam logic [IDX_W:0] VLEN_C  = (IDX_W+1)'(VLEN);
   localparam logic [IDX_W:0] VL_ONE  = (IDX_W+1)'(1);

   logic [0:0]              state_q, state_d;
   logic [2:0]              op_q, op_d;
   logic [IDX_W:0]          vl_q, vl_d;
   logic [IDX_W:0]          cnt_q, cnt_d;
   logic [DATA_W*VLEN-1:0]  src_a_q, src_a_d;
   logic [DATA_W*VLEN-1:0]  src_b_q, src_b_d;
   logic                    wb_valid_q, wb_valid_d;
   logic [REG_W-1:0]        wb_vd_q, wb_vd_d;
   logic [IDX_W-1:0]        wb_idx_q, wb_idx_d;
   logic [DATA_W-1:0]       wb_data_q, wb_data_d;
   logic                    wb_last_q, wb_last_d;

   logic                    accept;
   logic                    advance;
   logic [IDX_W:0]          vl_eff;
   logic [2:0]              sel_op;
   logic [DATA_W*VLEN-1:0]  sel_a, sel_b;
   logic [IDX_W-1:0]        sel_idx;
   logic [DATA_W-1:0]       a_elems [VLEN];
   logic [DATA_W-1:0]       b_elems [VLEN];
   logic [DATA_W-1:0]       alu_res;

   function automatic logic [DATA_W-1:0] alu(input logic [2:0] op,
                                             input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return a * b;
         3'd6:    return ($signed(a) < $signed(b)) ? a : b;
         default: return ($signed(a) > $signed(b)) ? a : b;
      endcase
   endfunction

   always_comb begin
      accept  = issue_valid && (state_q == ST_IDLE);
      advance = (state_q == ST_EXEC) && (!wb_valid_q || wb_ready);
      vl_eff  = (issue_vl > VLEN_C) ? VLEN_C : issue_vl;

      // Element 0 is computed straight from the issue bus so it lands one cycle after accept.
      sel_op  = accept ? issue_op    : op_q;
      sel_a   = accept ? issue_src_a : src_a_q;
      sel_b   = accept ? issue_src_b : src_b_q;
      sel_idx = accept ? '0          : cnt_q[IDX_W-1:0];
      for (int i = 0; i < VLEN; i++) begin
         a_elems[i] = sel_a[i*DATA_W +: DATA_W];
         b_elems[i] = sel_b[i*DATA_W +: DATA_W];
      end
      alu_res = alu(sel_op, a_elems[sel_idx], b_elems[sel_idx]);

      state_d    = state_q;
      op_d       = op_q;
      vl_d       = vl_q;
      cnt_d      = cnt_q;
      src_a_d    = src_a_q;
      src_b_d    = src_b_q;
      wb_valid_d = wb_valid_q;
      wb_vd_d    = wb_vd_q;
      wb_idx_d   = wb_idx_q;
      wb_data_d  = wb_data_q;
      wb_last_d  = wb_last_q;

      if (accept) begin
         op_d    = issue_op;
         vl_d    = vl_eff;
         src_a_d = issue_src_a;
         src_b_d = issue_src_b;
         if (vl_eff != '0) begin
            state_d    = ST_EXEC;
            wb_valid_d = 1'b1;
            wb_vd_d    = issue_vd;
            wb_idx_d   = '0;
            wb_data_d  = alu_res;
            wb_last_d  = (vl_eff == VL_ONE);
            cnt_d      = VL_ONE;
         end
      end else if (advance) begin
         if (cnt_q < vl_q) begin
            wb_valid_d = 1'b1;
            wb_idx_d   = cnt_q[IDX_W-1:0];
            wb_data_d  = alu_res;
            wb_last_d  = ((cnt_q + VL_ONE) == vl_q);
            cnt_d      = cnt_q + VL_ONE;
         end else begin
            // Last element just handshook: drain and release the issue side.
            wb_valid_d = 1'b0;
            wb_last_d  = 1'b0;
            state_d    = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         op_q       <= '0;
         vl_q       <= '0;
         cnt_q      <= '0;
         src_a_q    <= '0;
         src_b_q    <= '0;
         wb_valid_q <= 1'b0;
         wb_vd_q    <= '0;
         wb_idx_q   <= '0;
         wb_data_q  <= '0;
         wb_last_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         vl_q       <= vl_d;
         cnt_q      <= cnt_d;
         src_a_q    <= src_a_d;
         src_b_q    <= src_b_d;
         wb_valid_q <= wb_valid_d;
         wb_vd_q    <= wb_vd_d;
         wb_idx_q   <= wb_idx_d;
         wb_data_q  <= wb_data_d;
         wb_last_q  <= wb_last_d;
      end
   end

   assign issue_ready = (state_q == ST_IDLE);
   assign busy        = (state_q == ST_EXEC);
   assign wb_valid    = wb_valid_q;
   assign wb_vd       = wb_vd_q;
   assign wb_idx      = wb_idx_q;
   assign wb_data     = wb_data_q;
   assign wb_last     = wb_last_q;

endmodule

// File: tb/tb_vec_exec.sv
// tb/tb_vec_exec.sv - self-checking bench for vec_exec
// Directed and random instructions checked beat-by-beat against an arithmetic reference model.
module tb_vec_exec;

   localparam int DATA_W = 32;
   localparam int VLEN   = 8;
   localparam int IDX_W  = 3;
   localparam int REG_W  = 5;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    issue_valid;
   logic                    issue_ready;
   logic [2:0]              issue_op;
   logic [REG_W-1:0]        issue_vd;
   logic [IDX_W:0]          issue_vl;
   logic [DATA_W*VLEN-1:0]  issue_src_a;
   logic [DATA_W*VLEN-1:0]  issue_src_b;
   logic                    wb_valid;
   logic                    wb_ready;
   logic [REG_W-1:0]        wb_vd;
   logic [IDX_W-1:0]        wb_idx;
   logic [DATA_W-1:0]       wb_data;
   logic                    wb_last;
   logic                    busy;

   always #5 clk = ~clk;

   vec_exec #(.DATA_W(DATA_W), .VLEN(VLEN), .IDX_W(IDX_W), .REG_W(REG_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .issue_op    (issue_op),
      .issue_vd    (issue_vd),
      .issue_vl    (issue_vl),
      .issue_src_a (issue_src_a),
      .issue_src_b (issue_src_b),
      .wb_valid    (wb_valid),
      .wb_ready    (wb_ready),
      .wb_vd       (wb_vd),
      .wb_idx      (wb_idx),
      .wb_data     (wb_data),
      .wb_last     (wb_last),
      .busy        (busy)
   );

   typedef struct {
      int          idx;
      logic [31:0] data;
      int          vd;
      bit          last;
   } beat_t;

   beat_t       exp_q[$];
   logic [31:0] ta [VLEN];
   logic [31:0] tb [VLEN];
   int          n_cmp = 0;
   int          n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_op(input int op, input logic [31:0] a, input logic [31:0] b);
      longint unsigned ua = 64'(a);
      longint unsigned ub = 64'(b);
      longint unsigned m  = 64'h1_0000_0000;
      longint          sa = (ua >= 64'h8000_0000) ? longint'(ua) - longint'(m) : longint'(ua);
      longint          sb = (ub >= 64'h8000_0000) ? longint'(ub) - longint'(m) : longint'(ub);
      case (op)
         0: return 32'((ua + ub) % m);
         1: return 32'((ua + m - ub) % m);
         2: return a & b;
         3: return a | b;
         4: return a ^ b;
         5: return 32'((ua * ub) % m);
         6: return (sa <= sb) ? a : b;
         default: return (sa >= sb) ? a : b;
      endcase
   endfunction

   task automatic load_fields(input int op, input int vd, input int vl);
      int eff;
      issue_op = 3'(op);
      issue_vd = 5'(vd);
      issue_vl = 4'(vl);
      for (int i = 0; i < VLEN; i++) begin
         issue_src_a[i*DATA_W +: DATA_W] = ta[i];
         issue_src_b[i*DATA_W +: DATA_W] = tb[i];
      end
      eff = (vl > VLEN) ? VLEN : vl;
      for (int i = 0; i < eff; i++)
         exp_q.push_back('{idx: i, data: ref_op(op, ta[i], tb[i]), vd: vd, last: (i == eff - 1)});
   endtask

   // Called at a negedge with the stage idle; returns at the negedge one cycle after accept.
   task automatic issue(input int op, input int vd, input int vl, input bit hold);
      check("issue_ready_before_accept", 64'(issue_ready), 64'd1);
      load_fields(op, vd, vl);
      issue_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      issue_valid = hold;
   endtask

   task automatic collect(input bit rnd, input int lo, input int hi);
      int  got = 0;
      int  k   = 1;
      bit  rdy;
      while (got < exp_q.size()) begin
         if (k > 200) begin
            check("collect_timeout", 64'(got), 64'(exp_q.size()));
            break;
         end
         rdy      = rnd ? 1'($urandom_range(0, 1)) : !(k >= lo && k <= hi);
         wb_ready = rdy;
         check("wb_valid_beat", 64'(wb_valid), 64'd1);
         check("busy_beat", 64'(busy), 64'd1);
         check("issue_ready_beat", 64'(issue_ready), 64'd0);
         check("wb_idx", 64'(wb_idx), 64'(exp_q[got].idx));
         check("wb_data", 64'(wb_data), 64'(exp_q[got].data));
         check("wb_vd", 64'(wb_vd), 64'(exp_q[got].vd));
         check("wb_last", 64'(wb_last), 64'(exp_q[got].last));
         if (rdy) got++;
         @(negedge clk);
         k++;
      end
      wb_ready = 1'b1;
      check("wb_valid_after_last", 64'(wb_valid), 64'd0);
      check("issue_ready_after_last", 64'(issue_ready), 64'd1);
      check("busy_after_last", 64'(busy), 64'd0);
      exp_q.delete();
   endtask

   task automatic randomize_operands();
      for (int i = 0; i < VLEN; i++) begin
         case ($urandom_range(0, 3))
            0: ta[i] = 32'hFFFF_FFFF;
            1: ta[i] = 32'h8000_0000;
            default: ta[i] = $urandom;
         endcase
         tb[i] = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      beat_t first_q[$];
      beat_t second_q[$];

      reset       = 1'b0;
      issue_valid = 1'b0;
      issue_op    = '0;
      issue_vd    = '0;
      issue_vl    = '0;
      issue_src_a = '0;
      issue_src_b = '0;
      wb_ready    = 1'b1;

      // Reset held three cycles, then released.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_wb_valid_held", 64'(wb_valid), 64'd0);
      check("rst_busy_held", 64'(busy), 64'd0);
      reset = 1'b1;
      @(negedge clk);
      check("rst_issue_ready", 64'(issue_ready), 64'd1);
      check("rst_wb_valid", 64'(wb_valid), 64'd0);
      check("rst_wb_data", 64'(wb_data), 64'd0);
      check("rst_wb_idx", 64'(wb_idx), 64'd0);
      check("rst_wb_vd", 64'(wb_vd), 64'd0);
      check("rst_wb_last", 64'(wb_last), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);

      // ADD full vector, a[i]=i, b[i]=10, vd=4.
      for (int i = 0; i < VLEN; i++) begin
         ta[i] = 32'(i);
         tb[i] = 32'd10;
      end
      issue(0, 4, 8, 1'b0);
      for (int i = 0; i < VLEN; i++) exp_q[i].data = 32'(10 + i);
      collect(1'b0, 0, -1);

      // Arithmetic corner cases with spec-fixed results.
      ta[0] = 32'd0; tb[0] = 32'd1;
      issue(1, 1, 1, 1'b0);
      exp_q[0].data = 32'hFFFF_FFFF;
      collect(1'b0, 0, -1);

      ta[0] = 32'h0001_0000; tb[0] = 32'h0001_0000;
      issue(5, 2, 1, 1'b0);
      exp_q[0].data = 32'h0;
      collect(1'b0, 0, -1);

      ta[0] = 32'hFFFF_FFFF; tb[0] = 32'd1;
      issue(7, 3, 1, 1'b0);
      exp_q[0].data = 32'd1;
      collect(1'b0, 0, -1);

      issue(6, 3, 1, 1'b0);
      exp_q[0].data = 32'hFFFF_FFFF;
      collect(1'b0, 0, -1);

      // XOR with wb_ready low on cycles 2..4 after accept.
      randomize_operands();
      issue(4, 7, 3, 1'b0);
      collect(1'b0, 2, 4);

      // vl=0 is swallowed without output.
      issue(2, 3, 0, 1'b0);
      repeat (3) begin
         check("vl0_wb_valid", 64'(wb_valid), 64'd0);
         check("vl0_issue_ready", 64'(issue_ready), 64'd1);
         check("vl0_busy", 64'(busy), 64'd0);
         @(negedge clk);
      end

      // vl above VLEN clamps to VLEN.
      randomize_operands();
      issue(3, 9, 12, 1'b0);
      check("vl12_count", 64'(exp_q.size()), 64'd8);
      collect(1'b0, 0, -1);

      // Two queued instructions with issue_valid held high.
      randomize_operands();
      issue(0, 2, 2, 1'b1);
      first_q = exp_q;
      exp_q.delete();
      randomize_operands();
      load_fields(1, 3, 2);
      second_q = exp_q;
      exp_q = first_q;
      collect(1'b0, 0, -1);
      @(posedge clk);
      @(negedge clk);
      issue_valid = 1'b0;
      exp_q = second_q;
      collect(1'b0, 0, -1);

      // Random instructions with random back-pressure.
      repeat (10) begin
         randomize_operands();
         issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
               int'($urandom_range(1, 10)), 1'b0);
         collect(1'b1, 0, 0);
      end

      // Reset asserted while element 2 is on the output.
      randomize_operands();
      issue(5, 6, 8, 1'b0);
      @(negedge clk);
      @(negedge clk);
      check("midrst_pre_idx", 64'(wb_idx), 64'd2);
      check("midrst_pre_valid", 64'(wb_valid), 64'd1);
      reset = 1'b0;
      @(negedge clk);
      check("midrst_wb_valid", 64'(wb_valid), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_wb_data", 64'(wb_data), 64'd0);
      reset = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("midrst_no_more_valid", 64'(wb_valid), 64'd0);
         check("midrst_issue_ready", 64'(issue_ready), 64'd1);
      end
      exp_q.delete();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
